// File: rtl/cdb_arbiter.sv
// Round-robin scheduler of completed results onto NUM_PORTS registered CDB slots; 1 cycle grant-to-CDB latency.
// Losers see grant=0 and must hold their request; define CDB_ARB_STATS_EN for grant/conflict counters.
package cdb_arbiter_pkg;
  localparam int SAL_WIDTH = 32;

  typedef struct packed {
    logic [3:0]           tag;
    logic                 rdy;
    logic [SAL_WIDTH-1:0] data;
  } sal_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 10,
  parameter int NUM_PORTS = 2,
  parameter int ROB_SIZE  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  sal_t               req_i [NUM_REQ],
  output logic [NUM_REQ-1:0] grant_o,
  output sal_t               cdb_o [NUM_PORTS],
  input  logic               flush_i,
  input  logic [3:0]         flush_tag_i,
  input  logic [3:0]         rob_front_tag_i
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]        stat_grants_o,
  output logic [31:0]        stat_conflicts_o
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  sal_t          slot_d [NUM_PORTS];
  sal_t          cdb_q  [NUM_PORTS];

`ifdef CDB_ARB_STATS_EN
  int            n_valid;
  int            n_kept;
  logic [31:0]   stat_grants_q;
  logic [31:0]   stat_conflicts_q;
`endif

  // A tag survives the flush when it is strictly older than flush_tag, measured from the ROB head.
  function automatic logic tag_kept(input logic [3:0] tag, input logic [3:0] front,
                                    input logic [3:0] ftag);
    int d_tag;
    int d_flush;
    d_tag   = (int'(tag)  + 16 * ROB_SIZE - int'(front)) % ROB_SIZE;
    d_flush = (int'(ftag) + 16 * ROB_SIZE - int'(front)) % ROB_SIZE;
    return d_tag < d_flush;
  endfunction

  always_comb begin : select_p
    int   idx;
    int   cnt;
    sal_t cur;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) slot_d[k] = '0;
    idx = 0;
    cnt = 0;
    cur = '0;
`ifdef CDB_ARB_STATS_EN
    n_valid = 0;
    n_kept  = 0;
`endif
    if (!rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(ptr_q) + i) % NUM_REQ;
        cur = '0;
        for (int j = 0; j < NUM_REQ; j++) if (j == idx) cur = req_i[j];
        if (cur.rdy) begin
`ifdef CDB_ARB_STATS_EN
          n_valid = n_valid + 1;
`endif
          if (cnt < NUM_PORTS) begin
            for (int j = 0; j < NUM_REQ; j++) if (j == idx) grant_o[j] = 1'b1;
            // Squashed winners still consume their slot position, which stays empty.
            if (!flush_i || tag_kept(cur.tag, rob_front_tag_i, flush_tag_i)) begin
              for (int k = 0; k < NUM_PORTS; k++) if (k == cnt) slot_d[k] = cur;
`ifdef CDB_ARB_STATS_EN
              n_kept = n_kept + 1;
`endif
            end
            cnt   = cnt + 1;
            ptr_d = PW'((idx + 1) % NUM_REQ);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      for (int k = 0; k < NUM_PORTS; k++) cdb_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < NUM_PORTS; k++) cdb_q[k] <= slot_d[k];
    end
  end

  assign cdb_o = cdb_q;

`ifdef CDB_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_grants_q    <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_grants_q    <= stat_grants_q + 32'(n_kept);
      stat_conflicts_q <= stat_conflicts_q + ((n_valid > NUM_PORTS) ? 32'd1 : 32'd0);
    end
  end

  assign stat_grants_o    = stat_grants_q;
  assign stat_conflicts_o = stat_conflicts_q;
`endif

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
      a_grant_needs_rdy: assert property (@(posedge clk_i) grant_o[g] |-> req_i[g].rdy);
    end
  endgenerate

  a_grant_limit: assert property (@(posedge clk_i) $countones(grant_o) <= NUM_PORTS);

endmodule
